// File: rtl/alu_sched_pkg.sv
// Shared types, opcodes and latency helper for the scalar ALU scheduler.
package alu_sched_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] OP_MUL = 3'd4;
  localparam logic [SEL_W-1:0] OP_DIV = 3'd5;
  localparam logic [SEL_W-1:0] OP_MOD = 3'd6;

  // Number of cycles the ALU inputs must be held for a given opcode.
  function automatic int unsigned op_latency(input logic [SEL_W-1:0] sel,
                                             input int unsigned       mul_lat,
                                             input int unsigned       div_lat);
    int unsigned lat;
    lat = 1;
    case (sel)
      OP_MUL:         lat = mul_lat;
      OP_DIV, OP_MOD: lat = div_lat;
      default:        lat = 1;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/alu_scalar_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PTR_W-1:0] o_grant_idx,
  output logic             o_any
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  // Scan from the pointer with wrap; keep the first hit.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(N_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/alu_scalar_sched.sv
// Shares one external combinational ALU between N_REQ requesters with
// round-robin arbitration and a per-opcode hold latency.
module alu_scalar_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*SEL_W-1:0] req_sel,
  output logic [N_REQ-1:0]       resp_valid,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]       resp_data,
  output logic [FLAG_W-1:0]      resp_flags,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [SEL_W-1:0]       alu_sel,
  input  logic [WIDTH-1:0]       alu_c,
  input  logic [FLAG_W-1:0]      alu_flags,
  output logic                   busy
);

  localparam int unsigned PTR_W   = $clog2(N_REQ);
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [SEL_W-1:0]   r_alu_sel;
  logic [N_REQ-1:0]   r_resp_valid;
  logic [WIDTH-1:0]   r_resp_data;
  logic [FLAG_W-1:0]  r_resp_flags;
  logic               r_busy;

  logic [N_REQ-1:0]   w_grant;
  logic [PTR_W-1:0]   w_grant_idx;
  logic               w_any;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [SEL_W-1:0]   w_sel;
  logic [CNT_W-1:0]   w_lat;
  logic               w_req_hs;
  logic               w_cnt_done;
  logic               w_resp_hs;
  logic [PTR_W-1:0]   w_ptr_nxt;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req       (req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Operand mux for the granted requester.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_a   = req_a[i*WIDTH +: WIDTH];
        w_b   = req_b[i*WIDTH +: WIDTH];
        w_sel = req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  assign w_lat      = CNT_W'(op_latency(w_sel, MUL_LAT, DIV_LAT));
  assign w_req_hs   = (r_state == IDLE) && w_any;
  assign w_cnt_done = (r_state == EXEC) && (r_cnt == CNT_W'(1));
  assign w_resp_hs  = (r_state == RESP) && resp_ready[r_owner];
  assign w_ptr_nxt  = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

  // Grant is visible only while idle; the arbiter output is zero with no requests.
  assign req_ready  = (r_state == IDLE) ? w_grant : '0;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)                w_state_nxt = EXEC;
      EXEC:    if (r_cnt == CNT_W'(1))   w_state_nxt = RESP;
      RESP:    if (resp_ready[r_owner])  w_state_nxt = IDLE;
      default:                           w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch, hold counter, result capture and pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_cnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_flags <= '0;
      r_busy       <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_alu_a   <= w_a;
        r_alu_b   <= w_b;
        r_alu_sel <= w_sel;
        r_owner   <= w_grant_idx;
        r_cnt     <= w_lat;
        r_busy    <= 1'b1;
      end
      if (r_state == EXEC) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_cnt_done) begin
        r_resp_data  <= alu_c;
        r_resp_flags <= alu_flags;
        r_resp_valid <= N_REQ'(1) << r_owner;
      end
      if (w_resp_hs) begin
        r_resp_valid <= '0;
        r_rr_ptr     <= w_ptr_nxt;
        r_busy       <= 1'b0;
      end
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_flags = r_resp_flags;
  assign busy       = r_busy;

endmodule

// File: tb/tb_alu_scalar_sched.sv
// Scoreboard bench for alu_scalar_sched with a multi-cycle ALU model.
module tb_alu_scalar_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned ML = 2;
  localparam int unsigned DL = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N*3-1:0]   req_sel = '0;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ready = '0;
  logic [W-1:0]     resp_data;
  logic [3:0]       resp_flags;
  logic [W-1:0]     alu_a, alu_b, alu_c;
  logic [2:0]       alu_sel;
  logic [3:0]       alu_flags;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         idx;
    logic [W-1:0] d;
    logic [3:0] f;
    int         due;
    bit         seen;
  } exp_t;
  exp_t sbq[$];
  int   mptr = 0;

  alu_scalar_sched #(.N_REQ(N), .WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_flags (resp_flags),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_c      (alu_c),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500us");
    $fatal(1);
  end

  // ALU function: 0 and, 1 pass A, 2 add, 3 sub, 4 mul, 5 div, 6 mod, 7 xor.
  function automatic logic [W-1:0] ref_c(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] s);
    case (s)
      3'd0:    return a & b;
      3'd1:    return a;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a * b;
      3'd5:    return (b == 0) ? '1 : a / b;
      3'd6:    return (b == 0) ? a : a % b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [3:0] ref_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] s);
    logic [W-1:0] c;
    c = ref_c(a, b, s);
    return {c == 0, c[W-1], ^c, a < b};
  endfunction

  function automatic int lat_of(input logic [2:0] s);
    if (s == 3'd4) return ML;
    if (s == 3'd5 || s == 3'd6) return DL;
    return 1;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] sh;
    dbl = {v, v};
    for (int k = 0; k < N; k++) begin
      sh = dbl >> (p + k);
      if (sh[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  // The external ALU only yields a correct result once its inputs have been held for the op latency.
  logic [W+W+3-1:0] alu_prev;
  int               alu_hold = 0;
  always @(posedge clk) begin
    #1;
    if ({alu_a, alu_b, alu_sel} !== alu_prev) begin
      alu_prev = {alu_a, alu_b, alu_sel};
      alu_hold = 1;
    end else begin
      alu_hold++;
    end
  end
  always_comb begin
    alu_c     = ref_c(alu_a, alu_b, alu_sel);
    alu_flags = ref_f(alu_a, alu_b, alu_sel);
    if (alu_hold < lat_of(alu_sel)) begin
      alu_c     = ~alu_c;
      alu_flags = ~alu_flags;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event not seen or unexpected (cycle %0d)", nm, cyc);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t         e;
    bit           mb;
    int           g;
    logic [N-1:0] er;
    if (rst) begin
      sbq.delete();
      mptr = 0;
    end else begin
      mb = (sbq.size() != 0);
      chk("busy", 64'(busy), 64'(mb));
      er = '0;
      if (!mb) begin
        g = rr_pick(req_valid, mptr);
        if (g >= 0) er = N'(1) << g;
      end
      chk("req_ready", 64'(req_ready), 64'(er));
      if (mb) begin
        e = sbq[0];
        if (resp_valid != 0) begin
          if (!e.seen) begin
            chk("resp_latency", 64'(cyc), 64'(e.due));
            sbq[0].seen = 1'b1;
          end
          chk("resp_valid", 64'(resp_valid), 64'(N'(1) << e.idx));
          chk("resp_data", 64'(resp_data), 64'(e.d));
          chk("resp_flags", 64'(resp_flags), 64'(e.f));
          if (resp_ready[e.idx]) begin
            void'(sbq.pop_front());
            mptr = (e.idx + 1) % N;
          end
        end else if (e.seen || cyc > e.due) begin
          fail("resp_missing");
          void'(sbq.pop_front());
        end
      end else begin
        if (resp_valid != 0) fail("resp_spurious");
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            e.idx  = i;
            e.d    = ref_c(req_a[i*W +: W], req_b[i*W +: W], req_sel[i*3 +: 3]);
            e.f    = ref_f(req_a[i*W +: W], req_b[i*W +: W], req_sel[i*3 +: 3]);
            e.due  = cyc + 1 + lat_of(req_sel[i*3 +: 3]);
            e.seen = 1'b0;
            sbq.push_back(e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] s);
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_sel[i*3 +: 3] = s;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_accept(input int i);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        tick();
        req_valid[i] = 1'b0;
      end
    end
    if (!ok) fail("accept_timeout");
  endtask

  task automatic wait_resp(input int i);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (resp_valid[i]) ok = 1'b1;
    end
    if (!ok) fail("resp_timeout");
  endtask

  task automatic drain();
    logic [N-1:0] g;
    bit           done;
    done = 1'b0;
    tick();
    resp_ready = '1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      if (req_valid == 0 && !busy && resp_valid == 0) begin
        done = 1'b1;
      end else begin
        tick();
        req_valid = req_valid & ~g;
      end
    end
    if (!done) fail("drain_timeout");
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_resp_flags", 64'(resp_flags), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_alu_b", 64'(alu_b), 64'(0));
    chk("rst_alu_sel", 64'(alu_sel), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
  endtask

  // Stimulus.
  initial begin
    int           got;
    logic [N-1:0] hs;
    logic [W-1:0] ra, rb;

    do_reset();

    // Single add, response held while resp_ready is low.
    tick();
    set_req(0, 32'd10, 32'd2, 3'd2);
    @(negedge clk);
    chk("t1_req_ready", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_early_resp", 64'(resp_valid), 64'(0));
    @(negedge clk);
    chk("t1_resp_valid", 64'(resp_valid), 64'(4'b0001));
    chk("t1_resp_data", 64'(resp_data), 64'(12));
    repeat (3) @(negedge clk);
    chk("t1_resp_held", 64'(resp_data), 64'(12));
    drain();

    // Multiply then divide with operand hold.
    tick();
    set_req(0, 32'd10, 32'd2, 3'd4);
    wait_accept(0);
    @(negedge clk);
    chk("t2_alu_a", 64'(alu_a), 64'(10));
    chk("t2_alu_b", 64'(alu_b), 64'(2));
    chk("t2_alu_sel", 64'(alu_sel), 64'(4));
    wait_resp(0);
    chk("t2_mul", 64'(resp_data), 64'(20));
    drain();
    tick();
    set_req(0, 32'd10, 32'd2, 3'd5);
    wait_accept(0);
    wait_resp(0);
    chk("t2_div", 64'(resp_data), 64'(5));
    drain();

    // Round-robin order after reset, then wrap from pointer 2.
    do_reset();
    tick();
    resp_ready = '1;
    for (int i = 0; i < N; i++) set_req(i, 32'd10, 32'd2, 3'd3);
    for (int k = 0; k < N; k++) begin
      got = -1;
      for (int c = 0; c < 50 && got < 0; c++) begin
        @(negedge clk);
        for (int i = 0; i < N; i++) if (req_ready[i]) got = i;
      end
      chk("t3_rr_order", 64'(got), 64'(k));
      tick();
      if (got >= 0) req_valid[got] = 1'b0;
    end
    drain();
    tick();
    set_req(1, 32'd10, 32'd2, 3'd3);
    drain();
    tick();
    set_req(0, 32'd1, 32'd1, 3'd2);
    set_req(3, 32'd5, 32'd3, 3'd2);
    @(negedge clk);
    chk("t3_wrap_grant", 64'(req_ready), 64'(4'b1000));
    drain();

    // Backpressure on the response with other requests pending.
    tick();
    resp_ready = '0;
    set_req(0, 32'd7, 32'd3, 3'd2);
    wait_accept(0);
    set_req(1, 32'd6, 32'd4, 3'd0);
    set_req(2, 32'd9, 32'd1, 3'd7);
    wait_resp(0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_req_ready", 64'(req_ready), 64'(0));
      chk("t4_busy", 64'(busy), 64'(1));
      chk("t4_resp_data", 64'(resp_data), 64'(10));
    end
    drain();

    // Reset during a divide aborts it.
    tick();
    resp_ready = '1;
    set_req(0, 32'd100, 32'd7, 3'd5);
    wait_accept(0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t5_no_resp", 64'(resp_valid), 64'(0));
    end
    tick();
    set_req(2, 32'd10, 32'd3, 3'd1);
    wait_accept(2);
    wait_resp(2);
    chk("t5_pass", 64'(resp_data), 64'(10));
    drain();

    // resp_ready on non-owners is ignored.
    tick();
    resp_ready = '0;
    set_req(1, 32'd9, 32'd4, 3'd6);
    wait_accept(1);
    wait_resp(1);
    tick();
    resp_ready = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_owner_valid", 64'(resp_valid), 64'(4'b0010));
      chk("t6_busy", 64'(busy), 64'(1));
    end
    drain();

    // Random traffic with withdrawals and random response backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          req_valid[i] = 1'b0;
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
          rb = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 9)) : W'($urandom);
          set_req(i, ra, rb, 3'($urandom_range(0, 7)));
        end
      end
      resp_ready = N'($urandom);
    end
    drain();
    @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
